cnoc_echo_responder: RTL and testbench

Message-level responder on the far side of the CNOC portal link from the simulator bridge. It accepts request messages beat-by-beat on the `requests_0` enqueue interface and buffers each message whole. It then returns the message unchanged, header first, on the `indications_0` first/deq interface. It serves as the device end of the echo loopback and as a drop-in stand-in for a generated CNOC top in link-level tests.

---
 rtl/cnoc_echo_responder.sv | 177 +++++++++++++++++
 tb/tb_cnoc_echo_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnoc_echo_responder.sv
// cnoc_echo_responder
//
// Device end of the CNOC portal echo loopback. Request messages arrive one
// 32-bit beat at a time on the requests_0 enqueue interface and are buffered
// whole. The buffered message is then returned unchanged, header first, on
// the indications_0 first/deq interface. A message longer than MAX_WORDS is
// consumed and discarded, and err_drop pulses once when its last beat is taken.
//
// Header word: [31:16] methodId, [15:0] length in words including the header.
// A length of 0 is handled as 1, but the header is echoed with its original
// length field.
//
// Ports:
//   CLK, RST_N                          clock, synchronous active-low reset
//   requests_0_message_enq_v            request beat
//   EN_requests_0_message_enq           enqueue strobe
//   RDY_requests_0_message_enq          a beat can be accepted
//   requests_0_message_notFull          same as RDY_requests_0_message_enq
//   RDY_requests_0_message_notFull      constant 1
//   indications_0_message_first         current indication beat
//   RDY_indications_0_message_first    indication beat valid
//   EN_indications_0_message_deq        dequeue strobe
//   RDY_indications_0_message_deq       same as RDY_indications_0_message_first
//   indications_0_message_notEmpty      same as RDY_indications_0_message_first
//   RDY_indications_0_message_notEmpty  constant 1
//   err_drop                            one-cycle pulse after an oversize drop

module cnoc_echo_responder #(
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] requests_0_message_enq_v,
  input  logic        EN_requests_0_message_enq,
  output logic        RDY_requests_0_message_enq,
  output logic        requests_0_message_notFull,
  output logic        RDY_requests_0_message_notFull,
  output logic [31:0] indications_0_message_first,
  output logic        RDY_indications_0_message_first,
  input  logic        EN_indications_0_message_deq,
  output logic        RDY_indications_0_message_deq,
  output logic        indications_0_message_notEmpty,
  output logic        RDY_indications_0_message_notEmpty,
  output logic        err_drop
);

  localparam int unsigned IdxW   = $clog2(MAX_WORDS);
  localparam logic [16:0] MaxLen = 17'(MAX_WORDS);

  localparam logic [1:0] StHdr  = 2'd0;
  localparam logic [1:0] StBody = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;
  localparam logic [1:0] StSend = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] wr_idx_q, wr_idx_d;
  logic [15:0] rd_idx_q, rd_idx_d;
  logic [15:0] len_q, len_d;
  logic        err_drop_q, err_drop_d;

  logic [31:0] mem_q [MAX_WORDS];

  logic            rdy_enq, rdy_first;
  logic            enq_fire, deq_fire;
  logic [15:0]     hdr_len, hdr_len_eff;
  logic            hdr_fits;
  logic [15:0]     len_last;
  logic            mem_we;
  logic [IdxW-1:0] mem_waddr;

  assign rdy_enq   = (state_q != StSend);
  assign rdy_first = (state_q == StSend);

  // Strobes without the matching ready are ignored.
  assign enq_fire = EN_requests_0_message_enq & rdy_enq;
  assign deq_fire = EN_indications_0_message_deq & rdy_first;

  assign hdr_len     = requests_0_message_enq_v[15:0];
  assign hdr_len_eff = (hdr_len == 16'd0) ? 16'd1 : hdr_len;
  assign hdr_fits    = ({1'b0, hdr_len_eff} <= MaxLen);
  assign len_last    = len_q - 16'd1;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    len_d      = len_q;
    err_drop_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_idx_q[IdxW-1:0];
    case (state_q)
      StHdr: begin
        if (enq_fire) begin
          if (hdr_fits) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            len_d     = hdr_len_eff;
            if (hdr_len_eff == 16'd1) begin
              state_d  = StSend;
              rd_idx_d = 16'd0;
            end else begin
              state_d  = StBody;
              wr_idx_d = 16'd1;
            end
          end else begin
            // Oversize: keep the raw length so the whole message is consumed.
            len_d    = hdr_len;
            wr_idx_d = 16'd1;
            state_d  = StDrop;
          end
        end
      end
      StBody: begin
        if (enq_fire) begin
          mem_we   = 1'b1;
          wr_idx_d = wr_idx_q + 16'd1;
          if (wr_idx_q == len_last) begin
            state_d  = StSend;
            rd_idx_d = 16'd0;
          end
        end
      end
      StDrop: begin
        if (enq_fire) begin
          wr_idx_d = wr_idx_q + 16'd1;
          if (wr_idx_q == len_last) begin
            err_drop_d = 1'b1;
            state_d    = StHdr;
          end
        end
      end
      StSend: begin
        if (deq_fire) begin
          rd_idx_d = rd_idx_q + 16'd1;
          if (rd_idx_q == len_last) begin
            state_d = StHdr;
          end
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StHdr;
      wr_idx_q   <= 16'd0;
      rd_idx_q   <= 16'd0;
      len_q      <= 16'd0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      len_q      <= len_d;
      err_drop_q <= err_drop_d;
    end
  end

  // Message storage is not reset; it is only read in SEND after being written.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= requests_0_message_enq_v;
    end
  end

  assign RDY_requests_0_message_enq         = rdy_enq;
  assign requests_0_message_notFull         = rdy_enq;
  assign RDY_requests_0_message_notFull     = 1'b1;
  assign indications_0_message_first        = mem_q[rd_idx_q[IdxW-1:0]];
  assign RDY_indications_0_message_first    = rdy_first;
  assign RDY_indications_0_message_deq      = rdy_first;
  assign indications_0_message_notEmpty     = rdy_first;
  assign RDY_indications_0_message_notEmpty = 1'b1;
  assign err_drop                           = err_drop_q;

endmodule

// File: tb/tb_cnoc_echo_responder.sv
// Self-checking bench for cnoc_echo_responder (MAX_WORDS = 16).
// Reference: a message whose effective length fits is echoed beat-for-beat;
// an oversize message produces no indication and a single err_drop pulse.

module tb_cnoc_echo_responder;

  localparam int unsigned MaxW = 16;

  logic        CLK;
  logic        RST_N;
  logic [31:0] enq_v;
  logic        en_enq;
  logic        rdy_enq;
  logic        not_full;
  logic        rdy_not_full;
  logic [31:0] first;
  logic        rdy_first;
  logic        en_deq;
  logic        rdy_deq;
  logic        not_empty;
  logic        rdy_not_empty;
  logic        err_drop;

  int checks = 0;
  int errors = 0;

  cnoc_echo_responder #(
    .MAX_WORDS(MaxW)
  ) dut (
    .CLK                               (CLK),
    .RST_N                             (RST_N),
    .requests_0_message_enq_v          (enq_v),
    .EN_requests_0_message_enq         (en_enq),
    .RDY_requests_0_message_enq        (rdy_enq),
    .requests_0_message_notFull        (not_full),
    .RDY_requests_0_message_notFull    (rdy_not_full),
    .indications_0_message_first       (first),
    .RDY_indications_0_message_first   (rdy_first),
    .EN_indications_0_message_deq      (en_deq),
    .RDY_indications_0_message_deq     (rdy_deq),
    .indications_0_message_notEmpty    (not_empty),
    .RDY_indications_0_message_notEmpty(rdy_not_empty),
    .err_drop                          (err_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All stimulus changes at 1 time unit after a rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input logic [31:0] w);
    en_enq = 1'b1;
    enq_v  = w;
    tick();
    en_enq = 1'b0;
    enq_v  = $urandom;
  endtask

  task automatic deq();
    en_deq = 1'b1;
    tick();
    en_deq = 1'b0;
  endtask

  // Builds a message with random payload, sends it and checks the outcome.
  task automatic run_msg(input logic [15:0] mid, input int unsigned lf,
                         input int unsigned gap_max, input int unsigned stall_min,
                         input int unsigned stall_max);
    logic [31:0]  q[$];
    int unsigned  eff;
    int unsigned  stall;
    eff = (lf == 0) ? 1 : lf;
    q.push_back({mid, lf[15:0]});
    for (int i = 1; i < int'(eff); i++) q.push_back($urandom);
    for (int i = 0; i < q.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      check1("enq_rdy", rdy_enq, 1'b1);
      check1("no_drop_mid", err_drop, 1'b0);
      enq(q[i]);
    end
    if (eff <= MaxW) begin
      check1("first_rdy_after_last", rdy_first, 1'b1);
      check1("not_empty", not_empty, 1'b1);
      check1("enq_blocked", rdy_enq, 1'b0);
      check1("no_drop", err_drop, 1'b0);
      for (int i = 0; i < q.size(); i++) begin
        stall = $urandom_range(stall_max, stall_min);
        for (int s = 0; s < int'(stall); s++) begin
          check32("first_stable", first, q[i]);
          check1("rdy_stable", rdy_first, 1'b1);
          tick();
        end
        check32("echo", first, q[i]);
        check1("enq_blocked_send", rdy_enq, 1'b0);
        deq();
      end
      check1("first_rdy_done", rdy_first, 1'b0);
      check1("enq_rdy_done", rdy_enq, 1'b1);
    end else begin
      check1("drop_pulse", err_drop, 1'b1);
      check1("drop_no_ind", rdy_first, 1'b0);
      tick();
      check1("drop_pulse_end", err_drop, 1'b0);
      check1("drop_enq_rdy", rdy_enq, 1'b1);
    end
  endtask

  initial begin
    RST_N  = 1'b0;
    en_enq = 1'b0;
    en_deq = 1'b0;
    enq_v  = 32'h0;
    tick();
    tick();
    RST_N = 1'b1;

    // Reset state.
    check1("rst_rdy_enq", rdy_enq, 1'b1);
    check1("rst_not_full", not_full, 1'b1);
    check1("rst_rdy_not_full", rdy_not_full, 1'b1);
    check1("rst_rdy_first", rdy_first, 1'b0);
    check1("rst_rdy_deq", rdy_deq, 1'b0);
    check1("rst_not_empty", not_empty, 1'b0);
    check1("rst_rdy_not_empty", rdy_not_empty, 1'b1);
    check1("rst_err_drop", err_drop, 1'b0);

    // Illegal deq while idle is ignored.
    deq();
    check1("ill_deq_rdy_enq", rdy_enq, 1'b1);
    check1("ill_deq_rdy_first", rdy_first, 1'b0);

    // Single-word message.
    enq(32'h0005_0001);
    check1("one_rdy_first", rdy_first, 1'b1);
    check32("one_first", first, 32'h0005_0001);
    check1("one_rdy_enq", rdy_enq, 1'b0);
    // Illegal enq while sending is ignored.
    enq(32'h1111_2222);
    check32("ill_enq_first", first, 32'h0005_0001);
    check1("ill_enq_rdy_first", rdy_first, 1'b1);
    deq();
    check1("one_done_enq", rdy_enq, 1'b1);
    check1("one_done_first", rdy_first, 1'b0);

    // Three-word message back-to-back.
    enq(32'h0001_0003);
    enq(32'hDEAD_BEEF);
    enq(32'h1234_5678);
    check32("three_0", first, 32'h0001_0003);
    deq();
    check1("three_enq_hold1", rdy_enq, 1'b0);
    check32("three_1", first, 32'hDEAD_BEEF);
    deq();
    check1("three_enq_hold2", rdy_enq, 1'b0);
    check32("three_2", first, 32'h1234_5678);
    deq();
    check1("three_enq_rdy", rdy_enq, 1'b1);

    // Oversize (17 words) then a normal 2-word message.
    run_msg(16'h0002, 17, 0, 0, 0);
    enq(32'h0003_0002);
    enq(32'hCAFE_F00D);
    check32("after_drop_0", first, 32'h0003_0002);
    deq();
    check32("after_drop_1", first, 32'hCAFE_F00D);
    deq();
    check1("after_drop_done", rdy_enq, 1'b1);

    // Backpressure of 10 cycles before each deq.
    run_msg(16'h00AB, 2, 0, 10, 10);

    // Reset in the middle of sending.
    enq(32'h0009_0003);
    enq(32'hAAAA_5555);
    enq(32'h5555_AAAA);
    deq();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check1("mid_rst_first", rdy_first, 1'b0);
    check1("mid_rst_enq", rdy_enq, 1'b1);
    enq(32'h0004_0001);
    check32("post_rst_echo", first, 32'h0004_0001);
    deq();
    check1("post_rst_done", rdy_first, 1'b0);

    // Zero-length header.
    enq(32'h0007_0000);
    check32("l0_echo", first, 32'h0007_0000);
    check1("l0_rdy", rdy_first, 1'b1);
    deq();
    check1("l0_single", rdy_first, 1'b0);
    check1("l0_enq_rdy", rdy_enq, 1'b1);

    // Exact-fit boundary.
    run_msg(16'h0bee, MaxW, 1, 0, 1);

    // Randomized messages, including oversize and zero-length.
    for (int n = 0; n < 40; n++) begin
      run_msg(16'($urandom_range(16'hffff, 0)), $urandom_range(20, 0), 2, 0, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
